// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and WIDTH limits.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MIN_WIDTH = 1;
  localparam int MAX_WIDTH = 32;

  function automatic bit width_ok(input int w);
    return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
  endfunction

endpackage

// File: rtl/fulladder.sv
// Single-bit full adder cell, shared with the parallel ripple datapath.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // Purely combinational sum and carry of one bit slice.
  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: accepts two WIDTH-bit operands, adds them LSB-first through
// one fulladder slice per cycle, and presents {carry_out, sum} over a
// valid/ready handshake.
// Optional feature macro SERIAL_ADDER_SUB_EN adds a 'sub' input selecting a - b.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one bit slice per cycle, counter tracks bit position
// DONE  | result held with out_valid high until out_ready
module serial_adder
  import serial_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int                CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  if (!width_ok(WIDTH)) begin : g_width_err
    $error("serial_adder: WIDTH must lie in 1..32");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic             in_ready_q, in_ready_d;
  logic             sub_in;
  logic             fa_sum, fa_cout;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif

  fulladder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Next-state and datapath update; subtraction inverts b and seeds carry with 1.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    case (state_q)
      IDLE: begin
        if (in_ready_q && in_valid) begin
          a_sh_d  = a;
          b_sh_d  = sub_in ? ~b : b;
          carry_d = sub_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_sh_d = WIDTH'({fa_sum, sum_sh_q} >> 1);
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        carry_d  = fa_cout;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered so that in_ready stays low while reset is held.
    in_ready_d = (state_d == IDLE);
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      sum_sh_q   <= '0;
      carry_q    <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      sum_sh_q   <= sum_sh_d;
      carry_q    <= carry_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q == DONE);
  assign sum       = sum_sh_q;
  assign carry_out = carry_q;

endmodule
